// File: rtl/nn_pipe_pkg.sv
// Purpose: shared types and depth helpers for the forward-network alignment pipes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nn_pipe_pkg;

    localparam int NN_DATA_W = 16;

    // One matrix element: signed fixed point, carried bit-exact through the pipes.
    typedef logic signed [NN_DATA_W-1:0] elem_t;

    // Alignment depth for a layer: two register slots per remaining layer,
    // counting the layer itself.
    function automatic int layer_pipe_depth(input int total, input int layer);
        return 2 * (total - layer + 1);
    endfunction

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// Purpose: one elastic slot (valid flag plus M x N matrix register) of the alignment pipe.
// Latency: 1 cycle from upstream to this slot when adv is high.
// Backpressure: loads only on adv; data moves only with a valid upstream, otherwise holds.
//
// Ports: clk/reset (async active-low), flush (sync clear of valid only),
//        adv (slot may load this cycle), up_vld/up_dat (upstream slot or input),
//        vld/dat (slot contents, feed the next slot downstream).
module elastic_stage #(
    parameter int M      = 2,
    parameter int N      = 1,
    parameter int DATA_W = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               adv,
    input  logic                               up_vld,
    input  logic [0:M-1][0:N-1][DATA_W-1:0]    up_dat,
    output logic                               vld,
    output logic [0:M-1][0:N-1][DATA_W-1:0]    dat
);

    logic                            valid_q, valid_d;
    logic [0:M-1][0:N-1][DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Flush clears occupancy only; the data register keeps its contents.
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = up_vld;
            // Holding data on a bubble keeps downstream data stable and saves toggles.
            if (up_vld) begin
                data_d = up_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign vld = valid_q;
    assign dat = data_q;

endmodule

// File: rtl/layered_elastic_pipe.sv
// Purpose: layer-aligned M x N matrix delay line with valid/ready, bubble collapse, flush, occupancy.
// Latency: DEPTH cycles (accept at edge t -> out_valid after edge t+DEPTH-1), 1 matrix/cycle.
// Backpressure: in_ready drops only when every slot is valid and the tail is stalled, or during flush.
//
// Ports: clk, reset (async active-low), flush (sync clear),
//        in_valid/in_ready/data (upstream handshake and matrix),
//        out_valid/out_ready/out_data (downstream handshake and matrix),
//        occupancy (number of valid slots, 0..DEPTH).
module layered_elastic_pipe
    import nn_pipe_pkg::*;
#(
    parameter int M              = 2,
    parameter int N              = 1,
    parameter int DATA_W         = NN_DATA_W,
    parameter int TOTAL_LAYERS   = 3,
    parameter int LAYER_NUMBER   = 0,
    parameter int DEPTH_OVERRIDE = 0,
    localparam int DEPTH = (DEPTH_OVERRIDE > 0) ? DEPTH_OVERRIDE
                                                : layer_pipe_depth(TOTAL_LAYERS, LAYER_NUMBER),
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [0:M-1][0:N-1][DATA_W-1:0]    data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [0:M-1][0:N-1][DATA_W-1:0]    out_data,
    output logic [OCC_W-1:0]                   occupancy
);

    if (DEPTH < 1 || LAYER_NUMBER > TOTAL_LAYERS) begin : g_param_err
        $error("layered_elastic_pipe: bad parameters (DEPTH=%0d, LAYER_NUMBER=%0d, TOTAL_LAYERS=%0d)",
               DEPTH, LAYER_NUMBER, TOTAL_LAYERS);
    end

    logic [DEPTH-1:0]                stage_vld;
    logic [DEPTH-1:0]                stage_adv;
    logic [DEPTH-1:0]                up_vld;
    logic [0:M-1][0:N-1][DATA_W-1:0] stage_dat [DEPTH];
    logic [0:M-1][0:N-1][DATA_W-1:0] up_dat    [DEPTH];

    // Advance chain, flattened: adv_k = ~valid_k | adv_{k+1} with
    // adv_tail = out_ready | ~valid_tail unrolls to "out_ready, or some slot
    // from k to the tail is empty". Walking the run of full slots from the
    // tail avoids a combinational self-reference on the adv vector.
    always_comb begin
        logic full_run;
        full_run  = 1'b1;
        stage_adv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_run     = full_run & stage_vld[k];
            stage_adv[k] = out_ready | ~full_run;
        end
    end

    assign in_ready = stage_adv[0] & ~flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_vld[k] = in_valid & in_ready;
            assign up_dat[k] = data;
        end else begin : g_body
            assign up_vld[k] = stage_vld[k-1];
            assign up_dat[k] = stage_dat[k-1];
        end

        elastic_stage #(
            .M      (M),
            .N      (N),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush),
            .adv    (stage_adv[k]),
            .up_vld (up_vld[k]),
            .up_dat (up_dat[k]),
            .vld    (stage_vld[k]),
            .dat    (stage_dat[k])
        );
    end

    assign out_valid = stage_vld[DEPTH-1];
    assign out_data  = stage_dat[DEPTH-1];

    // Occupancy tracks handshakes rather than popcounting the valid flags.
    logic             in_hs;
    logic             out_hs;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_hs && !out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_hs && !in_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_layered_elastic_pipe.sv
// Purpose: randomized scoreboard bench for layered_elastic_pipe (M=2, N=1, DEPTH=8).
// Latency: model expects the oldest in-flight matrix at the output DEPTH-1 edges after its accept edge.
// Backpressure: model expects in_ready low only when DEPTH matrices are held and out_ready is low, or on flush.
module tb_layered_elastic_pipe;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] d;
        int          e;
    } item_t;

    logic                    clk;
    logic                    reset;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [0:1][0:0][15:0]   data;
    logic                    out_valid;
    logic                    out_ready;
    logic [0:1][0:0][15:0]   out_data;
    logic [3:0]              occupancy;

    int    n_vec;
    int    n_err;
    int    edge_cnt;
    int    seq;
    item_t sb[$];

    layered_elastic_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: an in-order queue of accepted matrices. The oldest one
    // moves every edge until it reaches the output, so it is presented once
    // DEPTH-1 edges have passed since its accept edge.
    always @(negedge clk) begin
        logic exp_ovld;
        logic exp_rdy;
        if (!reset) begin
            sb.delete();
            check("reset_out_valid", {31'd0, out_valid}, 32'd0);
            check("reset_occupancy", {28'd0, occupancy}, 32'd0);
        end else begin
            exp_ovld = (sb.size() > 0) && ((edge_cnt - sb[0].e) >= DEPTH - 1);
            exp_rdy  = !flush && !((sb.size() == DEPTH) && !out_ready);
            check("in_ready",  {31'd0, in_ready},  {31'd0, exp_rdy});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_ovld});
            check("occupancy", {28'd0, occupancy}, sb.size());
            if (exp_ovld) begin
                check("out_data", out_data, sb[0].d);
                if (out_ready) void'(sb.pop_front());
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && exp_rdy) begin
                sb.push_back('{d: data, e: edge_cnt + 1});
            end
        end
    end

    // Drive one cycle of inputs just after the active edge.
    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic rnd);
        @(posedge clk);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        if (iv) begin
            if (rnd) begin
                data[0][0] = 16'($urandom);
                data[1][0] = 16'($urandom);
            end else begin
                data[0][0] = 16'(2 * seq + 1);
                data[1][0] = 16'(2 * seq + 2);
            end
            seq++;
        end
    endtask

    task automatic idle(input int cycles, input logic ordy);
        for (int i = 0; i < cycles; i++) drive(1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        edge_cnt  = 0;
        seq       = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = '0;

        #1;
        check("por_out_data", out_data, 32'd0);
        #21;
        reset = 1'b1;

        // Stream with the consumer always ready.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1);

        // Backpressure fill, then drain in order.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b1);

        // Bubble collapse: sparse inputs pack against a stalled tail.
        for (int i = 0; i < 7; i++) drive((i % 3) == 0, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        idle(6, 1'b1);

        // Full pipe with simultaneous accept and emit.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b1);

        // Flush with five held and an input offered in the flush cycle.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Asynchronous reset mid-stream with four matrices in flight.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data",  out_data, 32'd0);
        check("async_rst_occupancy", {28'd0, occupancy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, 1'b1);
        end
        idle(12, 1'b1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
